// File: rtl/kalman_pkg.sv
// rtl/kalman_pkg.sv - shared types and constants for the Kalman filter blocks
package kalman_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRED_START = 3'd1,
        ST_PRED_WAIT  = 3'd2,
        ST_UPD_START  = 3'd3,
        ST_UPD_WAIT   = 3'd4,
        ST_CAPTURE    = 3'd5
    } kstate_e;

    localparam int OVR_CNT_W = 8;
    localparam int WDOG_W    = 16;

    localparam logic [OVR_CNT_W-1:0] OVR_ONE = OVR_CNT_W'(1);

    function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
        return (&v) ? v : v + OVR_ONE;
    endfunction

endpackage

// File: rtl/kalman_step_sequencer_if.sv
// rtl/kalman_step_sequencer_if.sv - sequencer to state-equation engine bundle
interface kalman_step_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int nos   = 4,
    parameter int noo   = 2,
    parameter int noi   = 2
);
    logic [WIDTH-1:0] U    [0:noi-1];
    logic [WIDTH-1:0] Y    [0:noo-1];
    logic [WIDTH-1:0] K_nk [0:nos-1][0:noo-1];
    logic [WIDTH-1:0] X_nk [0:nos-1];
    logic             Start_Prediction;
    logic             Start_Update;
    logic             ready_Prediction;
    logic             ready_Update;

    modport master (
        output U, Y, K_nk, Start_Prediction, Start_Update,
        input  ready_Prediction, ready_Update, X_nk
    );

    modport slave (
        input  U, Y, K_nk, Start_Prediction, Start_Update,
        output ready_Prediction, ready_Update, X_nk
    );
endinterface

// File: rtl/kalman_watchdog.sv
// rtl/kalman_watchdog.sv - per-phase cycle counter flagging the TIMEOUT-th waiting cycle
module kalman_watchdog
    import kalman_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT - 1);
    localparam logic [WDOG_W-1:0] ONE  = WDOG_W'(1);

    logic [WDOG_W-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of waiting cycles already spent, so the
    // TIMEOUT-th waiting cycle is the one that sees LAST.
    assign expire_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/kalman_step_sequencer.sv
// rtl/kalman_step_sequencer.sv - per-sample prediction/update sequencer with overrun and watchdog
module kalman_step_sequencer
    import kalman_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int nos     = 4,
    parameter int noo     = 2,
    parameter int noi     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 clear_flags,
    input  logic [WIDTH-1:0]     U_in [0:noi-1],
    input  logic [WIDTH-1:0]     Y_in [0:noo-1],
    input  logic [WIDTH-1:0]     K_ss [0:nos-1][0:noo-1],
    kalman_step_sequencer_if.master eng,
    output logic [WIDTH-1:0]     X_est [0:nos-1],
    output logic                 est_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout,
    output logic [OVR_CNT_W-1:0] overrun_cnt
);
    kstate_e state_q, state_d;

    logic [WIDTH-1:0] u_q [0:noi-1];
    logic [WIDTH-1:0] y_q [0:noo-1];
    logic [WIDTH-1:0] k_q [0:nos-1][0:noo-1];
    logic [WIDTH-1:0] x_q [0:nos-1];

    logic                 blank_q, blank_d;
    logic                 est_valid_q, est_valid_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;
    logic [OVR_CNT_W-1:0] cnt_q, cnt_d;

    logic wd_clr, wd_en, wd_expire, wd_fire;
    logic accept, drop, capture;
    logic pred_ok, upd_ok;

    // blank_q is high only in the first cycle of a wait state, masking a
    // ready level left over from the previous operation.
    assign pred_ok = eng.ready_Prediction && !blank_q;
    assign upd_ok  = eng.ready_Update && !blank_q;

    kalman_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (sample_tick) state_d = ST_PRED_START;
            ST_PRED_START: state_d = ST_PRED_WAIT;
            ST_PRED_WAIT:  if (pred_ok) state_d = ST_UPD_START;
                           else if (wd_expire) state_d = ST_IDLE;
            ST_UPD_START:  state_d = ST_UPD_WAIT;
            ST_UPD_WAIT:   if (upd_ok) state_d = ST_CAPTURE;
                           else if (wd_expire) state_d = ST_IDLE;
            ST_CAPTURE:    state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        eng.Start_Prediction = (state_q == ST_PRED_START);
        eng.Start_Update     = (state_q == ST_UPD_START);
        busy    = (state_q != ST_IDLE);
        wd_clr  = (state_q == ST_PRED_START) || (state_q == ST_UPD_START);
        wd_en   = (state_q == ST_PRED_WAIT) || (state_q == ST_UPD_WAIT);
        accept  = (state_q == ST_IDLE) && sample_tick;
        drop    = (state_q != ST_IDLE) && sample_tick;
        capture = (state_q == ST_CAPTURE);
        wd_fire = ((state_q == ST_PRED_WAIT) && !pred_ok && wd_expire) ||
                  ((state_q == ST_UPD_WAIT)  && !upd_ok  && wd_expire);

        blank_d     = wd_clr;
        est_valid_d = capture;

        // A set event in the same cycle as clear_flags takes priority.
        overrun_d = overrun_q;
        if (drop) overrun_d = 1'b1;
        else if (clear_flags) overrun_d = 1'b0;

        timeout_d = timeout_q;
        if (wd_fire) timeout_d = 1'b1;
        else if (clear_flags) timeout_d = 1'b0;

        cnt_d = cnt_q;
        if (drop) cnt_d = clear_flags ? OVR_ONE : sat_inc(cnt_q);
        else if (clear_flags) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q     <= 1'b0;
            est_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
            for (int i = 0; i < noi; i++) u_q[i] <= '0;
            for (int i = 0; i < noo; i++) y_q[i] <= '0;
            for (int i = 0; i < nos; i++) begin
                x_q[i] <= '0;
                for (int j = 0; j < noo; j++) k_q[i][j] <= '0;
            end
        end else begin
            blank_q     <= blank_d;
            est_valid_q <= est_valid_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
            if (accept) begin
                for (int i = 0; i < noi; i++) u_q[i] <= U_in[i];
                for (int i = 0; i < noo; i++) y_q[i] <= Y_in[i];
                for (int i = 0; i < nos; i++) begin
                    for (int j = 0; j < noo; j++) k_q[i][j] <= K_ss[i][j];
                end
            end
            if (capture) begin
                for (int i = 0; i < nos; i++) x_q[i] <= eng.X_nk[i];
            end
        end
    end

    assign eng.U       = u_q;
    assign eng.Y       = y_q;
    assign eng.K_nk    = k_q;
    assign X_est       = x_q;
    assign est_valid   = est_valid_q;
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;
    assign overrun_cnt = cnt_q;
endmodule

// File: tb/tb_kalman_step_sequencer.sv
// tb/tb_kalman_step_sequencer.sv - self-checking bench with a latency-driven mock engine
module tb_kalman_step_sequencer;
    localparam int W = 16, NOS = 4, NOO = 2, NOI = 2, TO = 10;

    logic         clk = 1'b0;
    logic         reset, sample_tick, clear_flags;
    logic [W-1:0] U_in [0:NOI-1];
    logic [W-1:0] Y_in [0:NOO-1];
    logic [W-1:0] K_ss [0:NOS-1][0:NOO-1];
    logic [W-1:0] X_est [0:NOS-1];
    logic         est_valid, busy, overrun, timeout;
    logic [7:0]   overrun_cnt;

    kalman_step_sequencer_if #(.WIDTH(W), .nos(NOS), .noo(NOO), .noi(NOI)) eng_if ();

    kalman_step_sequencer #(.WIDTH(W), .nos(NOS), .noo(NOO), .noi(NOI), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .clear_flags (clear_flags),
        .U_in        (U_in),
        .Y_in        (Y_in),
        .K_ss        (K_ss),
        .eng         (eng_if),
        .X_est       (X_est),
        .est_valid   (est_valid),
        .busy        (busy),
        .overrun     (overrun),
        .timeout     (timeout),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    // Mock engine: ready rises L cycles after the start pulse and stays high.
    int lp_v = 5, lu_v = 7, pc = 0, uc = 0;
    bit force_rp = 1'b0, force_ru = 1'b0;
    logic [W-1:0] xnk_v [0:NOS-1];

    always @(posedge clk) begin
        if (eng_if.Start_Prediction) pc <= 1; else if (pc != 0 && pc < 100000) pc <= pc + 1;
        if (eng_if.Start_Update) uc <= 1; else if (uc != 0 && uc < 100000) uc <= uc + 1;
    end
    assign eng_if.ready_Prediction = force_rp || (pc >= lp_v);
    assign eng_if.ready_Update     = force_ru || (uc >= lu_v);
    assign eng_if.X_nk             = xnk_v;

    int n_assert = 0, n_fail = 0;
    logic [W-1:0] u_exp [0:NOI-1];
    logic [W-1:0] y_exp [0:NOO-1];
    logic [W-1:0] k_exp [0:NOS-1][0:NOO-1];
    logic [W-1:0] x_exp [0:NOS-1];
    logic [W-1:0] x_new [0:NOS-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < NOI; i++) U_in[i] = W'($urandom);
        for (int i = 0; i < NOO; i++) Y_in[i] = W'($urandom);
        for (int i = 0; i < NOS; i++)
            for (int j = 0; j < NOO; j++) K_ss[i][j] = W'($urandom);
    endtask

    // One full step from a tick; expectations come from the latency formula.
    task automatic step(input int lp, input int lu, input int extra_tick, input int tail,
                        input bit frc, input string tag);
        int sp_k = -1, su_k = -1, ev_k = -1, npulse = 0, berr = 0, derr = 0, xerr = 0;
        int last_busy = lp + lu + 3;
        lp_v = frc ? 1 << 30 : lp;
        lu_v = frc ? 1 << 30 : lu;
        force_rp = frc;
        force_ru = frc;
        scramble_inputs();
        for (int i = 0; i < NOI; i++) u_exp[i] = U_in[i];
        for (int i = 0; i < NOO; i++) y_exp[i] = Y_in[i];
        for (int i = 0; i < NOS; i++) begin
            for (int j = 0; j < NOO; j++) k_exp[i][j] = K_ss[i][j];
            x_new[i] = W'($urandom);
            xnk_v[i] = x_new[i];
        end
        sample_tick = 1'b1;
        for (int k = 1; k <= lp + lu + 4 + tail; k++) begin
            @(negedge clk);
            if (k == 1) begin
                sample_tick = 1'b0;
                scramble_inputs();
            end
            if (eng_if.Start_Prediction) begin npulse++; if (sp_k < 0) sp_k = k; end
            if (eng_if.Start_Update) begin npulse++; if (su_k < 0) su_k = k; end
            if (est_valid) begin npulse++; if (ev_k < 0) ev_k = k; end
            if (busy !== (k <= last_busy)) berr++;
            for (int i = 0; i < NOI; i++) if (eng_if.U[i] !== u_exp[i]) derr++;
            for (int i = 0; i < NOO; i++) if (eng_if.Y[i] !== y_exp[i]) derr++;
            for (int i = 0; i < NOS; i++) begin
                for (int j = 0; j < NOO; j++) if (eng_if.K_nk[i][j] !== k_exp[i][j]) derr++;
                if (X_est[i] !== ((k <= last_busy) ? x_exp[i] : x_new[i])) xerr++;
            end
            if (extra_tick != 0 && k == extra_tick) begin
                sample_tick = 1'b1;
                scramble_inputs();
            end
            if (extra_tick != 0 && k == extra_tick + 1) sample_tick = 1'b0;
        end
        for (int i = 0; i < NOS; i++) x_exp[i] = x_new[i];
        force_rp = 1'b0;
        force_ru = 1'b0;
        chk({tag, ".start_pred_cycle"}, 64'(sp_k), 64'(1));
        chk({tag, ".start_upd_cycle"}, 64'(su_k), 64'(lp + 2));
        chk({tag, ".est_valid_cycle"}, 64'(ev_k), 64'(lp + lu + 4));
        chk({tag, ".pulse_count"}, 64'(npulse), 64'(3));
        chk({tag, ".busy_errors"}, 64'(berr), 64'(0));
        chk({tag, ".data_hold_errors"}, 64'(derr), 64'(0));
        chk({tag, ".x_est_errors"}, 64'(xerr), 64'(0));
    endtask

    initial begin
        int su_k, to_k, idle_k, nev, xerr, nbad, lp, lu, busy_until, dropped;
        reset = 1'b1;
        sample_tick = 1'b0;
        clear_flags = 1'b0;
        scramble_inputs();
        for (int i = 0; i < NOS; i++) begin x_exp[i] = '0; xnk_v[i] = '0; end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset.busy", busy, 0);
        chk("reset.start_pred", eng_if.Start_Prediction, 0);
        chk("reset.start_upd", eng_if.Start_Update, 0);
        chk("reset.est_valid", est_valid, 0);
        chk("reset.flags", {overrun, timeout, overrun_cnt}, 0);
        chk("reset.u0", eng_if.U[0], 0);
        chk("reset.k33", eng_if.K_nk[3][1], 0);
        chk("reset.x_est0", X_est[0], 0);

        step(5, 7, 0, 4, 1'b0, "basic");
        step(2, 2, 0, 4, 1'b1, "stale_ready");
        step(5, 7, 4, 4, 1'b0, "overrun_first");
        chk("overrun_first.overrun", overrun, 1);
        chk("overrun_first.cnt", overrun_cnt, 1);

        // Watchdog: ready_Update never comes.
        lp_v = 3;
        lu_v = 1 << 30;
        su_k = -1; to_k = -1; idle_k = -1; nev = 0; xerr = 0;
        sample_tick = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 1) sample_tick = 1'b0;
            if (eng_if.Start_Update && su_k < 0) su_k = k;
            if (timeout === 1'b1 && to_k < 0) to_k = k;
            if (busy === 1'b0 && idle_k < 0) idle_k = k;
            if (est_valid) nev++;
            for (int i = 0; i < NOS; i++) if (X_est[i] !== x_exp[i]) xerr++;
        end
        chk("timeout.start_upd_cycle", 64'(su_k), 64'(5));
        chk("timeout.flag_cycle", 64'(to_k), 64'(5 + TO + 1));
        chk("timeout.idle_cycle", 64'(idle_k), 64'(5 + TO + 1));
        chk("timeout.no_est_valid", 64'(nev), 64'(0));
        chk("timeout.x_est_errors", 64'(xerr), 64'(0));
        chk("timeout.sticky", timeout, 1);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("clear.timeout", timeout, 0);
        chk("clear.overrun", overrun, 0);
        chk("clear.cnt", overrun_cnt, 0);

        // Continuous ticks: a tick is dropped whenever a step is in flight.
        lp = $urandom_range(2, 9);
        lu = $urandom_range(2, 9);
        lp_v = lp;
        lu_v = lu;
        busy_until = -1;
        dropped = 0;
        for (int c = 0; c < 400; c++) begin
            sample_tick = 1'b1;
            if (c > busy_until) busy_until = c + lp + lu + 3;
            else dropped++;
            @(negedge clk);
            if (c == 99) chk("sat.cnt_at_100", overrun_cnt, (dropped > 255) ? 255 : dropped);
        end
        sample_tick = 1'b0;
        chk("sat.cnt_final", overrun_cnt, (dropped > 255) ? 255 : dropped);
        chk("sat.overrun", overrun, 1);
        for (int k = 0; k < 30 && busy; k++) @(negedge clk);
        chk("sat.drained", busy, 0);

        // Reset during PRED_WAIT.
        lp_v = 9;
        sample_tick = 1'b1;
        nbad = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) sample_tick = 1'b0;
            if (k == 3) reset = 1'b1;
            if (k == 4) begin
                reset = 1'b0;
                chk("rst_mid.busy", busy, 0);
                chk("rst_mid.flags", {overrun, timeout, overrun_cnt, est_valid}, 0);
                chk("rst_mid.u1", eng_if.U[1], 0);
                chk("rst_mid.x_est3", X_est[3], 0);
            end
            if (k >= 4 && (eng_if.Start_Update || eng_if.Start_Prediction || est_valid)) nbad++;
        end
        chk("rst_mid.no_pulses", 64'(nbad), 64'(0));
        for (int i = 0; i < NOS; i++) x_exp[i] = '0;
        step(3, 4, 0, 4, 1'b0, "after_reset");

        step(4, 3, 0, 0, 1'b0, "b2b_first");
        step(2, 5, 0, 4, 1'b0, "b2b_second");
        chk("b2b.overrun", overrun, 0);

        for (int r = 0; r < 6; r++)
            step($urandom_range(2, 9), $urandom_range(2, 9), 0, 3, 1'b0, "random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed no end expected end");
        $fatal(1);
    end
endmodule
